// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: LOAD/STORE funct3 encodings,
// data/instruction unions, byte-enable type and arbiter FSM state codes.
package riscv_mem_arbiter_pkg;

  typedef logic [3:0]  memBe_t;
  typedef logic [31:0] dataBus_t;

  typedef union packed {
    logic [31:0]     word;
    logic [3:0][7:0] bytes;
  } dataBus_u;

  typedef union packed {
    logic [31:0] raw;
    struct packed {
      logic [24:0] fields;
      logic [6:0]  opcode;
    } base;
  } instruction_u;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    STORE_SB = 3'b000,
    STORE_SH = 3'b001,
    STORE_SW = 3'b010
  } funct3SType_e;

  // Arbiter FSM state codes (memArbState_e values)
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_PEND = 2'd1;
  localparam logic [1:0] MA_PEND = 2'd2;
  localparam logic [1:0] ERR_RSP = 2'd3;

endpackage

// File: rtl/riscv_mem_arbiter_lsu_align.sv
// riscv_lsu_align: combinational byte-enable generation, store-data lane
// replication, load alignment/extension and misalignment/illegal-funct3 detection.
module riscv_lsu_align
  import riscv_mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output memBe_t      be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  dataBus_u    rd;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rd.word  = rdata;
  assign byte_sel = rd.bytes[addr];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    err       = 1'b0;
    if (we) begin
      case (funct3)
        STORE_SB: begin
          be        = 4'b0001 << addr;
          wdata_rep = {4{wdata[7:0]}};
        end
        STORE_SH: begin
          be        = 4'b0011 << {addr[1], 1'b0};
          wdata_rep = {2{wdata[15:0]}};
          err       = addr[0];
        end
        STORE_SW: err = (addr != 2'b00);
        default:  err = 1'b1;
      endcase
    end else begin
      case (funct3)
        LOAD_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
        LOAD_LBU: rdata_ext = {24'h0, byte_sel};
        LOAD_LH: begin
          rdata_ext = {{16{half_sel[15]}}, half_sel};
          err       = addr[0];
        end
        LOAD_LHU: begin
          rdata_ext = {16'h0, half_sel};
          err       = addr[0];
        end
        LOAD_LW:  err = (addr != 2'b00);
        default:  err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing unified memory between IF and MA (MA priority).
// Define MEM_ARB_FAIR_EN to let IF win after MAX_MA_BURST consecutive MA grants.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int MAX_MA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [2:0]  ma_funct3,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [31:0] ma_rdata,
  output logic        ma_err,
  output logic        mem_req,
  output logic        mem_we,
  output memBe_t      mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  if (MAX_MA_BURST < 1) begin : g_bad_burst
    $error("MAX_MA_BURST must be at least 1");
  end

  logic [1:0]  state;
  logic        flush_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [1:0]  lane_q;

  logic        idle, ma_pend, if_turn, sel_ma, sel_if;
  logic [2:0]  al_funct3;
  logic        al_we;
  logic [1:0]  al_addr;
  memBe_t      al_be;
  logic [31:0] al_wdata_rep, al_rdata_ext;
  logic        al_err;

  assign idle    = (state == IDLE);
  assign ma_pend = (state == MA_PEND);

  // The aligner sees the live request while issuing and the captured one while a load returns
  assign al_funct3 = ma_pend ? funct3_q : ma_funct3;
  assign al_we     = ma_pend ? we_q     : ma_we;
  assign al_addr   = ma_pend ? lane_q   : ma_addr[1:0];

  riscv_lsu_align u_align (
    .funct3    (al_funct3),
    .we        (al_we),
    .addr      (al_addr),
    .wdata     (ma_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata_rep),
    .rdata_ext (al_rdata_ext),
    .err       (al_err)
  );

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(MAX_MA_BURST + 1);
  logic [CW-1:0] burst_cnt;

  assign if_turn = if_req && (burst_cnt == CW'(MAX_MA_BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (if_gnt) begin
      burst_cnt <= '0;
    end else if (ma_gnt && if_req && (burst_cnt != CW'(MAX_MA_BURST))) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign if_turn = 1'b0;
`endif

  assign sel_ma = idle && ma_req && !if_turn;
  assign sel_if = idle && if_req && !sel_ma;

  assign mem_req   = sel_if || (sel_ma && !al_err);
  assign ma_gnt    = sel_ma && (al_err || mem_gnt);
  assign if_gnt    = sel_if && mem_gnt;
  assign mem_we    = mem_req && sel_ma && ma_we;
  assign mem_be    = !mem_req ? 4'b0000 : (sel_ma ? al_be : 4'b1111);
  assign mem_addr  = sel_ma ? (ma_addr & ~32'h3) : (sel_if ? (if_addr & ~32'h3) : 32'h0);
  assign mem_wdata = mem_we ? al_wdata_rep : 32'h0;

  // A flush seen on the response cycle itself must also hide the fetch
  assign if_rvalid = (state == IF_PEND) && mem_rvalid && !flush_q && !if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;

  assign ma_rvalid = (ma_pend && mem_rvalid) || (state == ERR_RSP);
  assign ma_err    = (state == ERR_RSP);
  assign ma_rdata  = (ma_pend && mem_rvalid && !we_q) ? al_rdata_ext : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      flush_q  <= 1'b0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      lane_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (ma_gnt) begin
            state    <= al_err ? ERR_RSP : MA_PEND;
            funct3_q <= ma_funct3;
            we_q     <= ma_we;
            lane_q   <= ma_addr[1:0];
          end else if (if_gnt) begin
            state   <= IF_PEND;
            flush_q <= if_flush;
          end
        end
        IF_PEND: begin
          if (mem_rvalid) begin
            state   <= IDLE;
            flush_q <= 1'b0;
          end else if (if_flush) begin
            flush_q <= 1'b1;
          end
        end
        MA_PEND: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed cases plus randomized
// transactions checked against a word-array memory model.
module tb_riscv_mem_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ma_req, ma_we, ma_gnt, ma_rvalid, ma_err;
  logic [2:0]  ma_funct3;
  logic [31:0] ma_addr, ma_wdata, ma_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_model [0:63];

  riscv_mem_arbiter #(.MAX_MA_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_funct3(ma_funct3), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid),
    .ma_rdata(ma_rdata), .ma_err(ma_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
    if (f3[1:0] == 2'd2 && a != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hff;
    h = (w >> (16 * a[1])) & 32'hffff;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hffffff00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hffff0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'd0:    return 4'(1 << a);
      3'd1:    return 4'(3 << a);
      default: return 4'hf;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hff) * 32'h01010101;
      3'd1:    return (wd & 32'hffff) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    int lane;
    logic [31:0] w;
    n = 1 << f3[1:0];
    w = mem_model[addr[7:2]];
    for (int k = 0; k < n; k++) begin
      lane = int'(addr[1:0]) + k;
      w = (w & ~(32'hff << (8 * lane))) | (((wd >> (8 * k)) & 32'hff) << (8 * lane));
    end
    mem_model[addr[7:2]] = w;
  endtask

  task automatic ma_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    logic e;
    logic granted;
    int lat;
    e = model_err(we, f3, addr[1:0]);
    granted = 1'b0;
    @(negedge clk);
    ma_req = 1'b1; ma_we = we; ma_funct3 = f3; ma_addr = addr; ma_wdata = wd;
    for (int c = 0; c < 12 && !granted; c++) begin
      if (c > 0) @(negedge clk);
      mem_gnt = (c >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (e) begin
        checkOutput("ma_err_no_mem_req", 32'(mem_req), 32'd0);
        checkOutput("ma_err_gnt", 32'(ma_gnt), 32'd1);
      end else begin
        checkOutput("ma_mem_req", 32'(mem_req), 32'd1);
        checkOutput("ma_gnt", 32'(ma_gnt), 32'(mem_gnt));
        if (mem_gnt) begin
          checkOutput("ma_mem_addr", mem_addr, addr & ~32'h3);
          checkOutput("ma_mem_we", 32'(mem_we), 32'(we));
          checkOutput("ma_mem_be", 32'(mem_be), we ? 32'(model_be(f3, addr[1:0])) : 32'hf);
          if (we) checkOutput("ma_mem_wdata", mem_wdata, model_wdata(f3, wd));
        end
      end
      granted = ma_gnt;
    end
    if (!granted) checkOutput("ma_grant_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ma_req = 1'b0; mem_gnt = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0800;
    if (e) begin
      #1;
      checkOutput("err_rsp_rvalid", 32'(ma_rvalid), 32'd1);
      checkOutput("err_rsp_err", 32'(ma_err), 32'd1);
      checkOutput("err_rsp_rdata", ma_rdata, 32'd0);
      checkOutput("err_rsp_no_if_gnt", 32'(if_gnt), 32'd0);
    end else begin
      lat = $urandom_range(1, 3);
      for (int c = 1; c < lat; c++) begin
        #1;
        checkOutput("ma_pend_rvalid", 32'(ma_rvalid), 32'd0);
        checkOutput("ma_pend_no_issue", 32'(mem_req), 32'd0);
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = we ? $urandom : mem_model[addr[7:2]];
      #1;
      checkOutput("ma_rsp_rvalid", 32'(ma_rvalid), 32'd1);
      checkOutput("ma_rsp_err", 32'(ma_err), 32'd0);
      checkOutput("ma_rsp_rdata", ma_rdata, we ? 32'd0 : model_load(f3, addr[1:0], mem_rdata));
      checkOutput("ma_rsp_no_if_gnt", 32'(if_gnt), 32'd0);
      if (we) model_store(f3, addr, wd);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; if_req = 1'b0; mem_gnt = 1'b0;
  endtask

  // flush_at: -1 for none, else cycle offset from grant (0) to response (lat)
  task automatic if_txn(input logic [31:0] addr, input int flush_at, input int lat);
    logic granted;
    logic [31:0] rd;
    granted = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    for (int c = 0; c < 12 && !granted; c++) begin
      if (c > 0) @(negedge clk);
      mem_gnt  = (c >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if_flush = mem_gnt ? (flush_at == 0) : 1'($urandom_range(0, 1));
      #1;
      checkOutput("if_mem_req", 32'(mem_req), 32'd1);
      checkOutput("if_gnt", 32'(if_gnt), 32'(mem_gnt));
      if (mem_gnt) begin
        checkOutput("if_mem_addr", mem_addr, addr & ~32'h3);
        checkOutput("if_mem_we", 32'(mem_we), 32'd0);
        checkOutput("if_mem_be", 32'(mem_be), 32'hf);
      end
      granted = if_gnt;
    end
    if (!granted) checkOutput("if_grant_timeout", 32'd0, 32'd1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if_req = 1'b0; mem_gnt = 1'b0;
      if_flush = (flush_at == c);
      if (c == lat) begin
        rd = $urandom;
        mem_rvalid = 1'b1; mem_rdata = rd;
      end
      #1;
      if (c < lat) begin
        checkOutput("if_pend_rvalid", 32'(if_rvalid), 32'd0);
      end else begin
        checkOutput("if_rsp_rvalid", 32'(if_rvalid), (flush_at >= 0) ? 32'd0 : 32'd1);
        checkOutput("if_rsp_rdata", if_rdata, (flush_at >= 0) ? 32'd0 : rd);
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b0; if_flush = 1'b0;
  endtask

  task automatic applyStimulus();
    logic fair;
    int cnt;
    logic exp_if;
`ifdef MEM_ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif

    // Directed cases
    mem_model[0] = 32'h80FF_1234;
    ma_txn(1'b0, 3'd0, 32'h0000_0103, 32'h0);
    ma_txn(1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD);
    ma_txn(1'b0, 3'd2, 32'h0000_0301, 32'h0);
    ma_txn(1'b1, 3'd3, 32'h0000_0010, 32'h1234_5678);

    // Both requesters at once: MA first, then IF in the very next IDLE cycle
    @(negedge clk);
    ma_req = 1'b1; ma_we = 1'b0; ma_funct3 = 3'd2; ma_addr = 32'h0000_0020;
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_gnt = 1'b1;
    #1;
    checkOutput("both_ma_gnt", 32'(ma_gnt), 32'd1);
    checkOutput("both_if_gnt", 32'(if_gnt), 32'd0);
    @(negedge clk);
    ma_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem_model[8];
    #1;
    checkOutput("both_ma_rdata", ma_rdata, mem_model[8]);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    checkOutput("both_if_gnt_next", 32'(if_gnt), 32'd1);
    @(negedge clk);
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    checkOutput("both_if_rdata", if_rdata, 32'h0000_0013);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Flushed fetch is hidden; the following fetch returns normally
    if_txn(32'h0000_0040, 1, 3);
    if_txn(32'h0000_0044, -1, 2);

    // Both held continuously: grant order from the burst rule
    cnt = 0;
    @(negedge clk);
    ma_req = 1'b1; ma_we = 1'b0; ma_funct3 = 3'd2; ma_addr = 32'h0000_0010;
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_gnt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      exp_if = fair && (cnt == MAX_BURST);
      checkOutput($sformatf("burst_if_gnt_%0d", i), 32'(if_gnt), 32'(exp_if));
      checkOutput($sformatf("burst_ma_gnt_%0d", i), 32'(ma_gnt), 32'(!exp_if));
      cnt = exp_if ? 0 : cnt + 1;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = mem_model[4];
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    ma_req = 1'b0; if_req = 1'b0; mem_gnt = 1'b0;

    // Randomized traffic against the memory model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        if_txn($urandom, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1, 2);
      else
        ma_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);
    end

    // Reset mid-fetch drops the response; a late mem_rvalid is ignored
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_gnt = 1'b1;
    #1;
    checkOutput("rst_mid_if_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk);
    if_req = 1'b0; mem_gnt = 1'b0; rst = 1'b1;
    #1;
    checkOutput("rst_mid_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("late_rvalid_if", 32'(if_rvalid), 32'd0);
    checkOutput("late_rvalid_ma", 32'(ma_rvalid), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    ma_txn(1'b0, 3'd4, 32'h0000_0011, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ma_req = 1'b0; ma_we = 1'b0; ma_funct3 = '0; ma_addr = '0; ma_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;

    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("reset_if_gnt", 32'(if_gnt), 32'd0);
    checkOutput("reset_ma_gnt", 32'(ma_gnt), 32'd0);
    checkOutput("reset_rvalids", {30'd0, if_rvalid, ma_rvalid}, 32'd0);
    checkOutput("reset_ma_err", 32'(ma_err), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_rdata", if_rdata | ma_rdata, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0; rst = 1'b0;

    applyStimulus();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
